// File: rtl/muldiv_unit.sv
// Iterative 32-cycle shift-add multiplier and restoring divider (RV32M ops).
// Define MULDIV_DIV_EN to build the divide datapath; otherwise funct3[2]=1 ops return 0.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   final_res;

`ifdef MULDIV_DIV_EN
    logic              rneg_q, rneg_d;
    logic [XLEN:0]     r_shift;
    logic              fits;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo, rem, quo_res, rem_res, div_res;
`endif

    // Operand sign handling: magnitudes go into the datapath, signs fix up the result.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b001: begin
                a_sgn = rv1[XLEN-1];
                b_sgn = rv2[XLEN-1];
            end
            3'b010: a_sgn = rv1[XLEN-1];
`ifdef MULDIV_DIV_EN
            3'b100, 3'b110: begin
                a_sgn = rv1[XLEN-1];
                b_sgn = rv2[XLEN-1];
            end
`endif
            default: ;
        endcase
        a_mag = a_sgn ? (~rv1 + 1'b1) : rv1;
        b_mag = b_sgn ? (~rv2 + 1'b1) : rv2;
    end

    // Multiply: acc = {partial high, multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign r_shift  = acc_q[2*XLEN-1:XLEN-1];
    assign fits     = (r_shift >= {1'b0, opb_q});
    assign rem_sub  = r_shift[XLEN-1:0] - opb_q;
    assign div_next = {(fits ? rem_sub : r_shift[XLEN-1:0]), acc_q[XLEN-2:0], fits};
    assign step     = funct3_q[2] ? div_next : mul_next;
`else
    assign step     = mul_next;
`endif

    assign prod    = neg_q ? (~step + 1'b1) : step;
    assign mul_res = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    assign quo       = step[XLEN-1:0];
    assign rem       = step[2*XLEN-1:XLEN];
    // Zero divisor forces all-ones quotient; the remainder naturally equals rv1.
    assign quo_res   = (opb_q == '0) ? '1 : (neg_q ? (~quo + 1'b1) : quo);
    assign rem_res   = rneg_q ? (~rem + 1'b1) : rem;
    assign div_res   = funct3_q[1] ? rem_res : quo_res;
    assign final_res = funct3_q[2] ? div_res : mul_res;
`else
    assign final_res = funct3_q[2] ? '0 : mul_res;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        rneg_d   = rneg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    funct3_d = funct3;
                    neg_d    = a_sgn ^ b_sgn;
                    opb_d    = a_mag;
                    acc_d    = {{XLEN{1'b0}}, b_mag};
`ifdef MULDIV_DIV_EN
                    rneg_d   = a_sgn;
                    if (funct3[2]) begin
                        opb_d = b_mag;
                        acc_d = {{XLEN{1'b0}}, a_mag};
                    end
`endif
                end
            end
            StCalc: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d  = StFin;
                    result_d = final_res;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StFin);
    assign result = result_q;

endmodule
